// File: rtl/cpu_pkg.sv
// Shared opcodes, step encoding and control-word layout for the
// hardwired control sequencer.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'h00;
    localparam logic [4:0] OP_LDI  = 5'h01;
    localparam logic [4:0] OP_ST   = 5'h02;
    localparam logic [4:0] OP_ADD  = 5'h03;
    localparam logic [4:0] OP_SUB  = 5'h04;
    localparam logic [4:0] OP_AND  = 5'h05;
    localparam logic [4:0] OP_OR   = 5'h06;
    localparam logic [4:0] OP_SHR  = 5'h07;
    localparam logic [4:0] OP_SHL  = 5'h08;
    localparam logic [4:0] OP_ROR  = 5'h09;
    localparam logic [4:0] OP_ROL  = 5'h0A;
    localparam logic [4:0] OP_ADDI = 5'h0B;
    localparam logic [4:0] OP_ANDI = 5'h0C;
    localparam logic [4:0] OP_ORI  = 5'h0D;
    localparam logic [4:0] OP_DIV  = 5'h0E;
    localparam logic [4:0] OP_MUL  = 5'h0F;
    localparam logic [4:0] OP_NEG  = 5'h10;
    localparam logic [4:0] OP_NOT  = 5'h11;
    localparam logic [4:0] OP_BR   = 5'h12;
    localparam logic [4:0] OP_IN   = 5'h13;
    localparam logic [4:0] OP_OUT  = 5'h14;
    localparam logic [4:0] OP_MFHI = 5'h15;
    localparam logic [4:0] OP_MFLO = 5'h16;
    localparam logic [4:0] OP_NOP  = 5'h17;
    localparam logic [4:0] OP_HALT = 5'h18;

    typedef enum logic [3:0] {
        ST_T0, ST_T1, ST_T2, ST_T3,
        ST_T4, ST_T5, ST_T6, ST_T7,
        ST_HALT
    } state_t;

    typedef enum logic [3:0] {
        CL_ALUR, CL_ALUI, CL_MD, CL_LDI,
        CL_LD, CL_ST, CL_BR, CL_MFHI,
        CL_MFLO, CL_IN, CL_OUT, CL_NOP,
        CL_HALT, CL_ILL
    } iclass_t;

    typedef struct packed {
        logic PCout;
        logic ZHIout;
        logic ZLOout;
        logic MDRout;
        logic HIout;
        logic LOout;
        logic InPortout;
        logic Cout;
        logic BAout;
        logic Rout;
        logic PCin;
        logic IncPC;
        logic MARin;
        logic MDRin;
        logic IRin;
        logic Yin;
        logic Zin;
        logic HIin;
        logic LOin;
        logic OutPortin;
        logic CONin;
        logic Rin;
        logic Gra;
        logic Grb;
        logic Grc;
        logic Read;
        logic Write;
    } ctrl_t;

    function automatic iclass_t op_class(input logic [4:0] op);
        iclass_t c;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL,
            OP_NEG, OP_NOT:           c = CL_ALUR;
            OP_ADDI, OP_ANDI, OP_ORI: c = CL_ALUI;
            OP_DIV, OP_MUL:           c = CL_MD;
            OP_LDI:                   c = CL_LDI;
            OP_LD:                    c = CL_LD;
            OP_ST:                    c = CL_ST;
            OP_BR:                    c = CL_BR;
            OP_MFHI:                  c = CL_MFHI;
            OP_MFLO:                  c = CL_MFLO;
            OP_IN:                    c = CL_IN;
            OP_OUT:                   c = CL_OUT;
            OP_NOP:                   c = CL_NOP;
            OP_HALT:                  c = CL_HALT;
            default:                  c = CL_ILL;
        endcase
        return c;
    endfunction

    function automatic state_t last_step(input iclass_t c);
        state_t s;
        case (c)
            CL_ALUR, CL_ALUI, CL_LDI: s = ST_T5;
            CL_MD, CL_BR:             s = ST_T6;
            CL_LD, CL_ST:             s = ST_T7;
            default:                  s = ST_T3;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Holds a memory step for MEM_LAT cycles; done marks the final cycle
// so the sequencer advances on that edge.
module mem_wait_counter #(
    parameter int MEM_LAT = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    output logic o_done
);

    localparam logic [3:0] LP_LAST = 4'(MEM_LAT - 1);

    logic [3:0] r_cnt;

    assign o_done = i_start && (r_cnt == LP_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_start && !o_done) begin
            r_cnt <= r_cnt + 4'd1;
        end else begin
            r_cnt <= '0;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer: registered T-step,
// combinational strobe decode from step and IR opcode.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        con,
    input  logic        stop,
    output logic        PCout,
    output logic        ZHIout,
    output logic        ZLOout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        InPortout,
    output logic        Cout,
    output logic        BAout,
    output logic        Rout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic        OutPortin,
    output logic        CONin,
    output logic        Rin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  alu_op,
    output logic        run,
    output logic        illegal
);

    state_t     r_state;
    state_t     w_next;
    state_t     w_last;
    ctrl_t      w_c;
    iclass_t    w_cls;
    logic [4:0] w_op;
    logic [4:0] w_alu;
    logic       w_ill;
    logic       w_mem;
    logic       w_done;
    logic       w_unused_ir;

    assign w_op        = ir[31:27];
    assign w_cls       = op_class(w_op);
    assign w_last      = last_step(w_cls);
    assign w_unused_ir = ^ir[26:0];

    mem_wait_counter #(
        .MEM_LAT(MEM_LAT)
    ) u_wait (
        .i_clk  (clock),
        .i_rst_n(clear),
        .i_start(w_mem),
        .o_done (w_done)
    );

    always_ff @(posedge clock) begin
        if (!clear) begin
            r_state <= ST_T0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_c   = '0;
        w_alu = 5'd0;
        w_ill = 1'b0;
        w_mem = 1'b0;
        if (r_state inside {ST_T3, ST_T4, ST_T5, ST_T6, ST_T7}) begin
            w_alu = w_op;
        end
        unique case (r_state)
            ST_T0: begin
                w_c.PCout = 1'b1;
                w_c.MARin = 1'b1;
                w_c.IncPC = 1'b1;
                w_c.Zin   = 1'b1;
            end
            ST_T1: begin
                w_c.ZLOout = 1'b1;
                w_c.PCin   = 1'b1;
                w_c.Read   = 1'b1;
                w_c.MDRin  = 1'b1;
                w_mem      = 1'b1;
            end
            ST_T2: begin
                w_c.MDRout = 1'b1;
                w_c.IRin   = 1'b1;
            end
            ST_T3: begin
                unique case (w_cls)
                    CL_ALUR, CL_ALUI: begin
                        w_c.Grb  = 1'b1;
                        w_c.Rout = 1'b1;
                        w_c.Yin  = 1'b1;
                    end
                    CL_MD: begin
                        w_c.Gra  = 1'b1;
                        w_c.Rout = 1'b1;
                        w_c.Yin  = 1'b1;
                    end
                    CL_LDI, CL_LD, CL_ST: begin
                        w_c.Grb   = 1'b1;
                        w_c.BAout = 1'b1;
                        w_c.Yin   = 1'b1;
                    end
                    CL_BR: begin
                        w_c.Gra   = 1'b1;
                        w_c.Rout  = 1'b1;
                        w_c.CONin = 1'b1;
                    end
                    CL_MFHI: begin
                        w_c.HIout = 1'b1;
                        w_c.Gra   = 1'b1;
                        w_c.Rin   = 1'b1;
                    end
                    CL_MFLO: begin
                        w_c.LOout = 1'b1;
                        w_c.Gra   = 1'b1;
                        w_c.Rin   = 1'b1;
                    end
                    CL_IN: begin
                        w_c.InPortout = 1'b1;
                        w_c.Gra       = 1'b1;
                        w_c.Rin       = 1'b1;
                    end
                    CL_OUT: begin
                        w_c.Gra       = 1'b1;
                        w_c.Rout      = 1'b1;
                        w_c.OutPortin = 1'b1;
                    end
                    CL_ILL:  w_ill = 1'b1;
                    default: ;
                endcase
            end
            ST_T4: begin
                unique case (w_cls)
                    CL_ALUR: begin
                        w_c.Grc  = 1'b1;
                        w_c.Rout = 1'b1;
                        w_c.Zin  = 1'b1;
                    end
                    CL_ALUI: begin
                        w_c.Cout = 1'b1;
                        w_c.Zin  = 1'b1;
                    end
                    CL_MD: begin
                        w_c.Grb  = 1'b1;
                        w_c.Rout = 1'b1;
                        w_c.Zin  = 1'b1;
                    end
                    // address compute: base + offset
                    CL_LDI, CL_LD, CL_ST: begin
                        w_c.Cout = 1'b1;
                        w_c.Zin  = 1'b1;
                        w_alu    = OP_ADD;
                    end
                    CL_BR: begin
                        w_c.PCout = 1'b1;
                        w_c.Yin   = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                unique case (w_cls)
                    CL_ALUR, CL_ALUI, CL_LDI: begin
                        w_c.ZLOout = 1'b1;
                        w_c.Gra    = 1'b1;
                        w_c.Rin    = 1'b1;
                    end
                    CL_MD: begin
                        w_c.ZLOout = 1'b1;
                        w_c.LOin   = 1'b1;
                    end
                    CL_LD, CL_ST: begin
                        w_c.ZLOout = 1'b1;
                        w_c.MARin  = 1'b1;
                    end
                    CL_BR: begin
                        w_c.Cout = 1'b1;
                        w_c.Zin  = 1'b1;
                        w_alu    = OP_ADD;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                unique case (w_cls)
                    CL_MD: begin
                        w_c.ZHIout = 1'b1;
                        w_c.HIin   = 1'b1;
                    end
                    CL_LD: begin
                        w_c.Read  = 1'b1;
                        w_c.MDRin = 1'b1;
                        w_mem     = 1'b1;
                    end
                    CL_ST: begin
                        w_c.Gra   = 1'b1;
                        w_c.Rout  = 1'b1;
                        w_c.MDRin = 1'b1;
                    end
                    CL_BR: begin
                        w_c.ZLOout = con;
                        w_c.PCin   = con;
                    end
                    default: ;
                endcase
            end
            ST_T7: begin
                unique case (w_cls)
                    CL_LD: begin
                        w_c.MDRout = 1'b1;
                        w_c.Gra    = 1'b1;
                        w_c.Rin    = 1'b1;
                    end
                    CL_ST: begin
                        w_c.Write = 1'b1;
                        w_mem     = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_T0:   w_next = ST_T1;
            ST_T1:   w_next = ST_T2;
            ST_T2:   w_next = ST_T3;
            ST_HALT: w_next = ST_HALT;
            default: begin
                if (r_state == w_last) begin
                    w_next = (stop || w_cls == CL_HALT) ? ST_HALT : ST_T0;
                end else begin
                    w_next = state_t'(r_state + 4'd1);
                end
            end
        endcase
        // memory steps hold until the wait counter reaches terminal count
        if (w_mem && !w_done) begin
            w_next = r_state;
        end
    end

    assign PCout     = w_c.PCout;
    assign ZHIout    = w_c.ZHIout;
    assign ZLOout    = w_c.ZLOout;
    assign MDRout    = w_c.MDRout;
    assign HIout     = w_c.HIout;
    assign LOout     = w_c.LOout;
    assign InPortout = w_c.InPortout;
    assign Cout      = w_c.Cout;
    assign BAout     = w_c.BAout;
    assign Rout      = w_c.Rout;
    assign PCin      = w_c.PCin;
    assign IncPC     = w_c.IncPC;
    assign MARin     = w_c.MARin;
    assign MDRin     = w_c.MDRin;
    assign IRin      = w_c.IRin;
    assign Yin       = w_c.Yin;
    assign Zin       = w_c.Zin;
    assign HIin      = w_c.HIin;
    assign LOin      = w_c.LOin;
    assign OutPortin = w_c.OutPortin;
    assign CONin     = w_c.CONin;
    assign Rin       = w_c.Rin;
    assign Gra       = w_c.Gra;
    assign Grb       = w_c.Grb;
    assign Grc       = w_c.Grc;
    assign Read      = w_c.Read;
    assign Write     = w_c.Write;
    assign alu_op    = w_alu;
    assign run       = (r_state != ST_HALT);
    assign illegal   = w_ill;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: two instances (MEM_LAT 1 and 3) against
// a per-instruction table of expected step strobes.
module tb_control_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  clr;
    logic [1:0]  con;
    logic [1:0]  stp;
    logic [31:0] irv  [2];
    logic [26:0] obs  [2];
    logic [4:0]  alu  [2];
    logic        runv [2];
    logic        illv [2];

    int n_total = 0;
    int n_bad   = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [26:0] o;
        control_sequencer #(
            .MEM_LAT(g == 0 ? 1 : 3)
        ) u_dut (
            .clock    (clk),
            .clear    (clr[g]),
            .ir       (irv[g]),
            .con      (con[g]),
            .stop     (stp[g]),
            .PCout    (o[26]),
            .ZHIout   (o[25]),
            .ZLOout   (o[24]),
            .MDRout   (o[23]),
            .HIout    (o[22]),
            .LOout    (o[21]),
            .InPortout(o[20]),
            .Cout     (o[19]),
            .BAout    (o[18]),
            .Rout     (o[17]),
            .PCin     (o[16]),
            .IncPC    (o[15]),
            .MARin    (o[14]),
            .MDRin    (o[13]),
            .IRin     (o[12]),
            .Yin      (o[11]),
            .Zin      (o[10]),
            .HIin     (o[9]),
            .LOin     (o[8]),
            .OutPortin(o[7]),
            .CONin    (o[6]),
            .Rin      (o[5]),
            .Gra      (o[4]),
            .Grb      (o[3]),
            .Grc      (o[2]),
            .Read     (o[1]),
            .Write    (o[0]),
            .alu_op   (alu[g]),
            .run      (runv[g]),
            .illegal  (illv[g])
        );
        assign obs[g] = o;
    end

    localparam logic [26:0] M_PCout  = 27'd1 << 26;
    localparam logic [26:0] M_ZHIout = 27'd1 << 25;
    localparam logic [26:0] M_ZLOout = 27'd1 << 24;
    localparam logic [26:0] M_MDRout = 27'd1 << 23;
    localparam logic [26:0] M_HIout  = 27'd1 << 22;
    localparam logic [26:0] M_LOout  = 27'd1 << 21;
    localparam logic [26:0] M_InPout = 27'd1 << 20;
    localparam logic [26:0] M_Cout   = 27'd1 << 19;
    localparam logic [26:0] M_BAout  = 27'd1 << 18;
    localparam logic [26:0] M_Rout   = 27'd1 << 17;
    localparam logic [26:0] M_PCin   = 27'd1 << 16;
    localparam logic [26:0] M_IncPC  = 27'd1 << 15;
    localparam logic [26:0] M_MARin  = 27'd1 << 14;
    localparam logic [26:0] M_MDRin  = 27'd1 << 13;
    localparam logic [26:0] M_IRin   = 27'd1 << 12;
    localparam logic [26:0] M_Yin    = 27'd1 << 11;
    localparam logic [26:0] M_Zin    = 27'd1 << 10;
    localparam logic [26:0] M_HIin   = 27'd1 << 9;
    localparam logic [26:0] M_LOin   = 27'd1 << 8;
    localparam logic [26:0] M_OutPin = 27'd1 << 7;
    localparam logic [26:0] M_CONin  = 27'd1 << 6;
    localparam logic [26:0] M_Rin    = 27'd1 << 5;
    localparam logic [26:0] M_Gra    = 27'd1 << 4;
    localparam logic [26:0] M_Grb    = 27'd1 << 3;
    localparam logic [26:0] M_Grc    = 27'd1 << 2;
    localparam logic [26:0] M_Read   = 27'd1 << 1;
    localparam logic [26:0] M_Write  = 27'd1;

    localparam logic [26:0] F0 = M_PCout | M_MARin | M_IncPC | M_Zin;
    localparam logic [26:0] F1 = M_ZLOout | M_PCin | M_Read | M_MDRin;
    localparam logic [26:0] F2 = M_MDRout | M_IRin;
    localparam logic [4:0]  ADD = 5'h03;

    typedef struct packed {
        logic [26:0] m;
        logic        ac;
        logic [4:0]  a;
        logic        il;
    } step_t;

    step_t q[$];

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [26:0] m, input int rep,
                        input logic ac, input logic [4:0] a, input logic il);
        step_t s;
        s = '{m: m, ac: ac, a: a, il: il};
        repeat (rep) q.push_back(s);
    endtask

    // Expected per-cycle behaviour of one instruction, fetch included.
    task automatic build(input logic [4:0] op, input logic c, input int lat);
        q.delete();
        push(F0, 1, 1'b0, 5'd0, 1'b0);
        push(F1, lat, 1'b0, 5'd0, 1'b0);
        push(F2, 1, 1'b0, 5'd0, 1'b0);
        if (op inside {5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08,
                       5'h09, 5'h0A, 5'h10, 5'h11}) begin
            push(M_Grb | M_Rout | M_Yin, 1, 1'b1, op, 1'b0);
            push(M_Grc | M_Rout | M_Zin, 1, 1'b1, op, 1'b0);
            push(M_ZLOout | M_Gra | M_Rin, 1, 1'b1, op, 1'b0);
        end else if (op inside {5'h0B, 5'h0C, 5'h0D}) begin
            push(M_Grb | M_Rout | M_Yin, 1, 1'b1, op, 1'b0);
            push(M_Cout | M_Zin, 1, 1'b1, op, 1'b0);
            push(M_ZLOout | M_Gra | M_Rin, 1, 1'b1, op, 1'b0);
        end else if (op inside {5'h0E, 5'h0F}) begin
            push(M_Gra | M_Rout | M_Yin, 1, 1'b1, op, 1'b0);
            push(M_Grb | M_Rout | M_Zin, 1, 1'b1, op, 1'b0);
            push(M_ZLOout | M_LOin, 1, 1'b1, op, 1'b0);
            push(M_ZHIout | M_HIin, 1, 1'b1, op, 1'b0);
        end else if (op inside {5'h00, 5'h01, 5'h02}) begin
            push(M_Grb | M_BAout | M_Yin, 1, 1'b1, op, 1'b0);
            push(M_Cout | M_Zin, 1, 1'b1, ADD, 1'b0);
            if (op == 5'h01) begin
                push(M_ZLOout | M_Gra | M_Rin, 1, 1'b1, op, 1'b0);
            end else begin
                push(M_ZLOout | M_MARin, 1, 1'b1, op, 1'b0);
                if (op == 5'h00) begin
                    push(M_Read | M_MDRin, lat, 1'b1, op, 1'b0);
                    push(M_MDRout | M_Gra | M_Rin, 1, 1'b1, op, 1'b0);
                end else begin
                    push(M_Gra | M_Rout | M_MDRin, 1, 1'b1, op, 1'b0);
                    push(M_Write, lat, 1'b1, op, 1'b0);
                end
            end
        end else if (op == 5'h12) begin
            push(M_Gra | M_Rout | M_CONin, 1, 1'b1, op, 1'b0);
            push(M_PCout | M_Yin, 1, 1'b1, op, 1'b0);
            push(M_Cout | M_Zin, 1, 1'b1, ADD, 1'b0);
            push(c ? (M_ZLOout | M_PCin) : 27'd0, 1, 1'b1, op, 1'b0);
        end else if (op == 5'h13) begin
            push(M_InPout | M_Gra | M_Rin, 1, 1'b1, op, 1'b0);
        end else if (op == 5'h14) begin
            push(M_Gra | M_Rout | M_OutPin, 1, 1'b1, op, 1'b0);
        end else if (op == 5'h15) begin
            push(M_HIout | M_Gra | M_Rin, 1, 1'b1, op, 1'b0);
        end else if (op == 5'h16) begin
            push(M_LOout | M_Gra | M_Rin, 1, 1'b1, op, 1'b0);
        end else if (op inside {5'h17, 5'h18}) begin
            push(27'd0, 1, 1'b1, op, 1'b0);
        end else begin
            push(27'd0, 1, 1'b1, op, 1'b1);
        end
    endtask

    // Entered at a negedge with instance k in T0; leaves it the same way.
    task automatic run_instr(input int k, input logic [31:0] irw,
                             input logic c, input int stop_at);
        logic [4:0] op;
        logic       halts;
        string      t;
        op     = irw[31:27];
        irv[k] = irw;
        con[k] = c;
        build(op, c, lat_of(k));
        halts = (op == 5'h18) || (stop_at >= 0 && stop_at < q.size());
        for (int i = 0; i < q.size(); i++) begin
            t = $sformatf("k%0d op%02h cyc%0d", k, op, i);
            check({t, " strobes"}, 32'(obs[k]), 32'(q[i].m));
            check({t, " run"}, 32'(runv[k]), 32'd1);
            check({t, " illegal"}, 32'(illv[k]), 32'(q[i].il));
            if (q[i].ac) check({t, " alu_op"}, 32'(alu[k]), 32'(q[i].a));
            if (i == stop_at) stp[k] = 1'b1;
            @(negedge clk);
        end
        if (halts) begin
            for (int i = 0; i < 3; i++) begin
                t = $sformatf("k%0d op%02h halt%0d", k, op, i);
                check({t, " strobes"}, 32'(obs[k]), 32'd0);
                check({t, " run"}, 32'(runv[k]), 32'd0);
                check({t, " illegal"}, 32'(illv[k]), 32'd0);
                @(negedge clk);
            end
            stp[k] = 1'b0;
            clr[k] = 1'b0;
            @(negedge clk);
            clr[k] = 1'b1;
        end
    endtask

    task automatic measure_len(input int k, input logic [31:0] irw,
                               input int exp_len);
        int n;
        irv[k] = irw;
        con[k] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (obs[k] !== F0 && n < 64);
        check($sformatf("k%0d op%02h length", k, irw[31:27]), n, exp_len);
    endtask

    task automatic select(input int k);
        clr = 2'b00;
        @(negedge clk);
        clr[k] = 1'b1;
    endtask

    task automatic random_run(input int k, input int n);
        logic [31:0] r;
        for (int i = 0; i < n; i++) begin
            r = $urandom;
            run_instr(k, r, 1'($urandom_range(0, 1)), -1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit");
        $fatal(1);
    end

    initial begin
        clr    = 2'b00;
        con    = 2'b00;
        stp    = 2'b00;
        irv[0] = 32'h0;
        irv[1] = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check("reset strobes", 32'(obs[0]), 32'(F0));
        check("reset run", 32'(runv[0]), 32'd1);
        check("reset illegal", 32'(illv[0]), 32'd0);
        check("reset alu_op", 32'(alu[0]), 32'd0);
        clr[0] = 1'b1;

        measure_len(0, 32'h1A2B8000, 6);
        run_instr(0, 32'h1A2B8000, 1'b0, -1);

        irv[0] = {5'h00, 27'h0123456};
        repeat (5) @(negedge clk);
        check("midLD T5 strobes", 32'(obs[0]), 32'(M_ZLOout | M_MARin));
        clr[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clr[0] = 1'b1;
        check("midLD reset strobes", 32'(obs[0]), 32'(F0));
        check("midLD reset run", 32'(runv[0]), 32'd1);
        check("midLD reset illegal", 32'(illv[0]), 32'd0);
        check("midLD reset alu_op", 32'(alu[0]), 32'd0);

        run_instr(0, {5'h12, 27'h0AB0000}, 1'b0, -1);
        run_instr(0, {5'h12, 27'h0AB0000}, 1'b1, -1);
        run_instr(0, {5'h1F, 27'h0000000}, 1'b0, -1);
        run_instr(0, {5'h0F, 27'h1234567}, 1'b0, 4);
        random_run(0, 40);

        select(1);
        measure_len(1, {5'h00, 27'h0111111}, 12);
        run_instr(1, {5'h00, 27'h0111111}, 1'b0, -1);
        run_instr(1, {5'h02, 27'h0222222}, 1'b0, -1);
        run_instr(1, {5'h12, 27'h0333333}, 1'b1, -1);
        run_instr(1, {5'h0F, 27'h0444444}, 1'b0, 6);
        run_instr(1, {5'h18, 27'h0000000}, 1'b0, -1);
        random_run(1, 40);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
